// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline register with a two-entry skid buffer (main + skid) and registered in_ready.
// Define EX_MEM_STAGE_FLAGS_EN to carry zero/negative result flags with each entry.
module ex_mem_stage #(
  parameter int DATA_W = 16,
  parameter int RD_W   = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_result,
  input  logic [DATA_W-1:0] in_st_data,
  input  logic [RD_W-1:0]   in_rd,
  input  logic [2:0]        in_ctl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_result,
  output logic [DATA_W-1:0] out_st_data,
  output logic [RD_W-1:0]   out_rd,
  output logic [2:0]        out_ctl,
  output logic              out_zero,
  output logic              out_neg,
  output logic [1:0]        dbg_state
);

  // Handshake: a transfer happens on a rising edge where valid && ready; the
  // producer holds its fields stable while valid is high and ready is low.
  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} state_t;

  state_t state_q, state_d;
  logic   ready_q;
  logic   accept, deliver;
  logic   load_main_in, load_skid_in, load_main_skid;

  logic [DATA_W-1:0] skid_result, skid_st_data;
  logic [RD_W-1:0]   skid_rd;
  logic [2:0]        skid_ctl;

  assign accept    = in_valid && ready_q;
  assign deliver   = (state_q != EMPTY) && out_ready;
  assign in_ready  = ready_q;
  assign out_valid = (state_q != EMPTY);
  assign dbg_state = state_q;

  always_comb begin
    state_d        = state_q;
    load_main_in   = 1'b0;
    load_skid_in   = 1'b0;
    load_main_skid = 1'b0;
    if (flush) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: if (accept) begin
          state_d      = ONE;
          load_main_in = 1'b1;
        end
        ONE: begin
          if (accept && deliver) begin
            load_main_in = 1'b1;
          end else if (accept) begin
            state_d      = FULL;
            load_skid_in = 1'b1;
          end else if (deliver) begin
            state_d = EMPTY;
          end
        end
        FULL: if (deliver) begin
          state_d        = ONE;
          load_main_skid = 1'b1;
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  // in_ready comes straight from a flop; it reflects the state being entered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      ready_q <= (state_d != FULL);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_result   <= '0;
      out_st_data  <= '0;
      out_rd       <= '0;
      out_ctl      <= '0;
      skid_result  <= '0;
      skid_st_data <= '0;
      skid_rd      <= '0;
      skid_ctl     <= '0;
    end else begin
      if (load_main_in) begin
        out_result  <= in_result;
        out_st_data <= in_st_data;
        out_rd      <= in_rd;
        out_ctl     <= in_ctl;
      end else if (load_main_skid) begin
        out_result  <= skid_result;
        out_st_data <= skid_st_data;
        out_rd      <= skid_rd;
        out_ctl     <= skid_ctl;
      end
      if (load_skid_in) begin
        skid_result  <= in_result;
        skid_st_data <= in_st_data;
        skid_rd      <= in_rd;
        skid_ctl     <= in_ctl;
      end
    end
  end

`ifdef EX_MEM_STAGE_FLAGS_EN
  logic skid_zero, skid_neg;

  // Flags are computed once at capture so the MEM stage sees them registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_zero  <= 1'b0;
      out_neg   <= 1'b0;
      skid_zero <= 1'b0;
      skid_neg  <= 1'b0;
    end else begin
      if (load_main_in) begin
        out_zero <= (in_result == '0);
        out_neg  <= in_result[DATA_W-1];
      end else if (load_main_skid) begin
        out_zero <= skid_zero;
        out_neg  <= skid_neg;
      end
      if (load_skid_in) begin
        skid_zero <= (in_result == '0);
        skid_neg  <= in_result[DATA_W-1];
      end
    end
  end
`else
  assign out_zero = 1'b0;
  assign out_neg  = 1'b0;
`endif

endmodule
